sample_loader: RTL and testbench

Upstream feeder for the neural network datapath. Accepts a word-serial stream of fixed-point training samples over a valid/ready handshake, splits each sample into its sx input words and sl target words, and writes them into the x memory (one n-bit word per address) and the t memory (one n*sl-bit row per sample). It fills the sample BRAMs before training starts and reports how many complete samples were stored, so the control unit can iterate over `batch` samples.

---
 rtl/sample_loader.sv | 210 +++++++++++++++++++++
 tb/tb_sample_loader.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_loader.sv
// sample_loader
// Upstream feeder for the neural network datapath. Takes a word-serial
// stream of fixed-point training samples over a valid/ready handshake and
// scatters each sample into the x memory (sx words, one word per address)
// and the t memory (sl words packed into one row per sample). It reports
// how many complete samples were stored so the control unit knows how many
// samples it can iterate over.
//
// The word width n normally comes from the fixed-point configuration. Words
// are passed through untouched, so the fraction position does not matter
// here.

module sample_loader #(
   parameter int a  = 32,
   parameter int n  = 16,
   parameter int sx = 2,
   parameter int sl = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [n-1:0]    batch,
   input  logic [n-1:0]    in_data,
   input  logic            in_valid,
   output logic            in_ready,
   output logic [a-1:0]    x_addr,
   output logic [n-1:0]    x_din,
   output logic [7:0]      x_we,
   output logic [a-1:0]    t_addr,
   output logic [n*sl-1:0] t_din,
   output logic [7:0]      t_we,
   output logic            busy,
   output logic            done,
   output logic [n-1:0]    count
);

   // The word counter must hold indices up to the longer of the two segments.
   localparam int MAXW = (sx > sl) ? sx : sl;
   localparam int CW   = (MAXW > 1) ? $clog2(MAXW) : 1;

   localparam logic [CW-1:0] SX_LAST = CW'(sx - 1);
   localparam logic [CW-1:0] SL_LAST = CW'(sl - 1);

   localparam logic [7:0] WE_ALL  = 8'hFF;
   localparam logic [7:0] WE_NONE = 8'h00;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] LOAD_X = 2'd1;
   localparam logic [1:0] LOAD_T = 2'd2;
   localparam logic [1:0] DONE   = 2'd3;

   // Control state
   logic [1:0]    state_q,   state_d;
   logic [n-1:0]  batch_q,   batch_d;
   logic [n-1:0]  count_q,   count_d;
   logic [a-1:0]  xPtr_q,    xPtr_d;
   logic [a-1:0]  tPtr_q,    tPtr_d;
   logic [CW-1:0] wordCnt_q, wordCnt_d;
   logic [n*sl-1:0] tAsm_q,  tAsm_d;

   // Registered memory write ports and status
   logic [a-1:0]    xAddr_q, xAddr_d;
   logic [n-1:0]    xDin_q,  xDin_d;
   logic [7:0]      xWe_q,   xWe_d;
   logic [a-1:0]    tAddr_q, tAddr_d;
   logic [n*sl-1:0] tDin_q,  tDin_d;
   logic [7:0]      tWe_q,   tWe_d;
   logic            done_q,  done_d;

   logic            accept;
   logic [n*sl-1:0] tRow;

   // The block only consumes words while it is actively filling a sample.
   assign in_ready = (state_q == LOAD_X) || (state_q == LOAD_T);
   assign accept   = in_valid & in_ready;
   assign busy     = (state_q != IDLE);

   // Target row as it would look with the current word merged in; the first
   // target word of a sample ends up in the least significant slot.
   always_comb begin
      tRow = tAsm_q;
      tRow[n*wordCnt_q +: n] = in_data;
   end

   // Next-state logic: sequencing through the x and t segments of each
   // sample and preparing the one-cycle memory write for every accepted word.
   always_comb begin
      state_d   = state_q;
      batch_d   = batch_q;
      count_d   = count_q;
      xPtr_d    = xPtr_q;
      tPtr_d    = tPtr_q;
      wordCnt_d = wordCnt_q;
      tAsm_d    = tAsm_q;
      xAddr_d   = xAddr_q;
      xDin_d    = xDin_q;
      xWe_d     = WE_NONE;
      tAddr_d   = tAddr_q;
      tDin_d    = tDin_q;
      tWe_d     = WE_NONE;
      done_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               batch_d   = batch;
               count_d   = '0;
               xPtr_d    = '0;
               tPtr_d    = '0;
               wordCnt_d = '0;
               state_d   = (batch == '0) ? DONE : LOAD_X;
            end
         end

         LOAD_X: begin
            if (accept) begin
               xAddr_d = xPtr_q;
               xDin_d  = in_data;
               xWe_d   = WE_ALL;
               xPtr_d  = xPtr_q + a'(1);
               if (wordCnt_q == SX_LAST) begin
                  wordCnt_d = '0;
                  state_d   = LOAD_T;
               end else begin
                  wordCnt_d = wordCnt_q + CW'(1);
               end
            end
         end

         LOAD_T: begin
            if (accept) begin
               tAsm_d = tRow;
               if (wordCnt_q == SL_LAST) begin
                  tAddr_d   = tPtr_q;
                  tDin_d    = tRow;
                  tWe_d     = WE_ALL;
                  tPtr_d    = tPtr_q + a'(1);
                  count_d   = count_q + n'(1);
                  wordCnt_d = '0;
                  state_d   = (count_d == batch_q) ? DONE : LOAD_X;
               end else begin
                  wordCnt_d = wordCnt_q + CW'(1);
               end
            end
         end

         DONE: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control registers; reset abandons any partially loaded sample.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         batch_q   <= '0;
         count_q   <= '0;
         xPtr_q    <= '0;
         tPtr_q    <= '0;
         wordCnt_q <= '0;
         tAsm_q    <= '0;
      end else begin
         state_q   <= state_d;
         batch_q   <= batch_d;
         count_q   <= count_d;
         xPtr_q    <= xPtr_d;
         tPtr_q    <= tPtr_d;
         wordCnt_q <= wordCnt_d;
         tAsm_q    <= tAsm_d;
      end
   end

   // Memory write ports and done pulse are registered so the BRAMs see clean
   // signals; write enables last exactly one cycle per accepted word.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         xAddr_q <= '0;
         xDin_q  <= '0;
         xWe_q   <= WE_NONE;
         tAddr_q <= '0;
         tDin_q  <= '0;
         tWe_q   <= WE_NONE;
         done_q  <= 1'b0;
      end else begin
         xAddr_q <= xAddr_d;
         xDin_q  <= xDin_d;
         xWe_q   <= xWe_d;
         tAddr_q <= tAddr_d;
         tDin_q  <= tDin_d;
         tWe_q   <= tWe_d;
         done_q  <= done_d;
      end
   end

   assign x_addr = xAddr_q;
   assign x_din  = xDin_q;
   assign x_we   = xWe_q;
   assign t_addr = tAddr_q;
   assign t_din  = tDin_q;
   assign t_we   = tWe_q;
   assign done   = done_q;
   assign count  = count_q;

endmodule

// File: tb/tb_sample_loader.sv
// Testbench for sample_loader: drives word streams with several valid
// patterns and compares the captured memory writes against the layout
// that follows directly from the sample format.

module tb_sample_loader;

   localparam int A  = 32;
   localparam int W  = 16;
   localparam int SX = 2;
   localparam int SL = 2;
   localparam int SW = SX + SL;

   logic          clk;
   logic          rst;
   logic          start;
   logic [W-1:0]  batch;
   logic [W-1:0]  in_data;
   logic          in_valid;
   logic          in_ready;
   logic [A-1:0]  x_addr;
   logic [W-1:0]  x_din;
   logic [7:0]    x_we;
   logic [A-1:0]  t_addr;
   logic [W*SL-1:0] t_din;
   logic [7:0]    t_we;
   logic          busy;
   logic          done;
   logic [W-1:0]  count;

   int testsRun;
   int testsFailed;

   // Stream offered to the DUT and what the observed write ports produced
   logic [W-1:0]    stream[$];
   logic [W-1:0]    xMem[int];
   logic [W*SL-1:0] tMem[int];
   int xWrites, tWrites, spuriousWe, badWe, doneCnt, doneCycle;
   int readySeen, stallCnt, busyErr, countErr, timedOut;

   sample_loader #(.a(A), .n(W), .sx(SX), .sl(SL)) dut (
      .clk(clk), .rst(rst), .start(start), .batch(batch),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .x_addr(x_addr), .x_din(x_din), .x_we(x_we),
      .t_addr(t_addr), .t_din(t_din), .t_we(t_we),
      .busy(busy), .done(done), .count(count)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: sample s occupies stream words s*SW .. s*SW+SW-1,
   // the first SX go to x addresses s*SX.., the rest form t row s.
   function automatic logic [W-1:0] expX(int addr);
      return stream[(addr / SX) * SW + (addr % SX)];
   endfunction

   function automatic logic [W*SL-1:0] expT(int s);
      logic [W*SL-1:0] r;
      r = '0;
      for (int k = 0; k < SL; k++) r[W*k +: W] = stream[s*SW + SX + k];
      return r;
   endfunction

   function automatic logic [W-1:0] xAt(int addr);
      return xMem.exists(addr) ? xMem[addr] : '0;
   endfunction

   function automatic logic [W*SL-1:0] tAt(int row);
      return tMem.exists(row) ? tMem[row] : '0;
   endfunction

   // Starts a run and plays the stream, recording everything the write ports
   // show; mode 0 = continuous valid, 1 = toggling, 2 = random.
   task automatic driveRun(input int b, input int mode, input int glitchCycle, input int glitchBatch);
      int  idx;
      int  m;
      int  limit;
      bit  lastAcc;
      bit  acc;
      xMem.delete();
      tMem.delete();
      xWrites = 0; tWrites = 0; spuriousWe = 0; badWe = 0; doneCnt = 0;
      doneCycle = -1; readySeen = 0; stallCnt = 0; busyErr = 0; countErr = 0;
      timedOut = 0;
      limit = b * SW * 8 + 20;
      idx = 0;
      lastAcc = 1'b0;
      @(negedge clk);
      start = 1'b1;
      batch = W'(b);
      in_valid = 1'b0;
      m = 0;
      while (1) begin
         @(negedge clk);
         start = (m == glitchCycle);
         if (m == glitchCycle) batch = W'(glitchBatch);
         if (x_we === 8'hFF) begin
            xMem[int'(x_addr)] = x_din;
            xWrites++;
            if (!lastAcc) spuriousWe++;
         end else if (x_we !== 8'h00) badWe++;
         if (t_we === 8'hFF) begin
            tMem[int'(t_addr)] = t_din;
            tWrites++;
            if (!lastAcc) spuriousWe++;
            if (count !== W'(tWrites)) countErr++;
         end else if (t_we !== 8'h00) badWe++;
         if ((x_we === 8'hFF) && (t_we === 8'hFF)) badWe++;
         if (done === 1'b1) begin
            doneCnt++;
            if (doneCycle < 0) doneCycle = m;
         end
         if (in_ready === 1'b1) readySeen++;
         if (busy !== (doneCycle < 0)) busyErr++;
         if (doneCycle >= 0 && m == doneCycle + 1) break;
         if (m >= limit) begin
            timedOut = 1;
            break;
         end
         if (doneCycle < 0 && idx < stream.size()) begin
            case (mode)
               0:       in_valid = 1'b1;
               1:       in_valid = (m % 2 == 0);
               default: in_valid = 1'($urandom_range(0, 1));
            endcase
         end else begin
            in_valid = 1'b0;
         end
         in_data = in_valid ? stream[idx] : W'($urandom);
         acc = in_valid && (in_ready === 1'b1);
         if (in_valid && !acc) stallCnt++;
         if (acc) idx++;
         lastAcc = acc;
         m++;
      end
      start = 1'b0;
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; start = 1'b0; batch = '0; in_data = '0; in_valid = 1'b0;
      repeat (2) @(negedge clk);
      testsRun++;
      if ({in_ready, x_addr, x_din, x_we, t_addr, t_din, t_we, busy, done, count} !== '0) begin
         testsFailed++;
         $display("[TB] FAIL reset_values: got ready=%b xa=%0h xd=%0h xwe=%0h ta=%0h td=%0h twe=%0h busy=%b done=%b cnt=%0d, expected all zero",
                  in_ready, x_addr, x_din, x_we, t_addr, t_din, t_we, busy, done, count);
      end
      rst = 1'b1;
      @(negedge clk);
      testsRun++;
      if ({in_ready, busy} !== 2'b00) begin
         testsFailed++;
         $display("[TB] FAIL idle_after_reset: got ready=%b busy=%b expected 0 0", in_ready, busy);
      end
   endtask

   task automatic test_single();
      stream = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
      driveRun(1, 0, -1, 0);
      for (int i = 0; i < SX; i++) begin
         testsRun++;
         if (!xMem.exists(i) || xMem[i] !== expX(i)) begin
            testsFailed++;
            $display("[TB] FAIL single_x%0d: got %h expected %h", i, xAt(i), expX(i));
         end
      end
      testsRun++;
      if (!tMem.exists(0) || tMem[0] !== 32'h04000300) begin
         testsFailed++;
         $display("[TB] FAIL single_t0: got %h expected 04000300", tAt(0));
      end
      testsRun++;
      if (count !== 16'd1 || doneCycle != SW + 1 || doneCnt != 1 || busyErr != 0) begin
         testsFailed++;
         $display("[TB] FAIL single_done: got count=%0d doneCycle=%0d pulses=%0d busyErr=%0d expected 1 %0d 1 0",
                  count, doneCycle, doneCnt, busyErr, SW + 1);
      end
   endtask

   task automatic test_batch3();
      stream.delete();
      for (int i = 1; i <= 12; i++) stream.push_back(W'(i));
      driveRun(3, 0, -1, 0);
      for (int i = 0; i < 3 * SX; i++) begin
         testsRun++;
         if (!xMem.exists(i) || xMem[i] !== expX(i)) begin
            testsFailed++;
            $display("[TB] FAIL batch3_x%0d: got %h expected %h", i, xAt(i), expX(i));
         end
      end
      for (int s = 0; s < 3; s++) begin
         testsRun++;
         if (!tMem.exists(s) || tMem[s] !== expT(s)) begin
            testsFailed++;
            $display("[TB] FAIL batch3_t%0d: got %h expected %h", s, tAt(s), expT(s));
         end
      end
      testsRun++;
      if (tWrites != 3 || xWrites != 6 || stallCnt != 0 || spuriousWe != 0 || badWe != 0) begin
         testsFailed++;
         $display("[TB] FAIL batch3_writes: got t=%0d x=%0d stalls=%0d spurious=%0d bad=%0d expected 3 6 0 0 0",
                  tWrites, xWrites, stallCnt, spuriousWe, badWe);
      end
      testsRun++;
      if (count !== 16'd3 || doneCycle != 3 * SW + 1 || countErr != 0 || busyErr != 0) begin
         testsFailed++;
         $display("[TB] FAIL batch3_done: got count=%0d doneCycle=%0d countErr=%0d busyErr=%0d expected 3 %0d 0 0",
                  count, doneCycle, countErr, busyErr, 3 * SW + 1);
      end
   endtask

   task automatic test_toggle();
      stream.delete();
      for (int i = 0; i < 2 * SW; i++) stream.push_back(W'($urandom));
      driveRun(2, 1, -1, 0);
      for (int i = 0; i < 2 * SX; i++) begin
         testsRun++;
         if (!xMem.exists(i) || xMem[i] !== expX(i)) begin
            testsFailed++;
            $display("[TB] FAIL toggle_x%0d: got %h expected %h", i, xAt(i), expX(i));
         end
      end
      for (int s = 0; s < 2; s++) begin
         testsRun++;
         if (!tMem.exists(s) || tMem[s] !== expT(s)) begin
            testsFailed++;
            $display("[TB] FAIL toggle_t%0d: got %h expected %h", s, tAt(s), expT(s));
         end
      end
      testsRun++;
      if (xWrites != 4 || tWrites != 2 || spuriousWe != 0 || count !== 16'd2 || doneCnt != 1) begin
         testsFailed++;
         $display("[TB] FAIL toggle_summary: got x=%0d t=%0d spurious=%0d count=%0d pulses=%0d expected 4 2 0 2 1",
                  xWrites, tWrites, spuriousWe, count, doneCnt);
      end
   endtask

   task automatic test_random();
      int b;
      for (int iter = 0; iter < 4; iter++) begin
         b = int'($urandom_range(1, 6));
         stream.delete();
         for (int i = 0; i < b * SW; i++) stream.push_back(W'($urandom));
         driveRun(b, 2, -1, 0);
         for (int i = 0; i < b * SX; i++) begin
            testsRun++;
            if (!xMem.exists(i) || xMem[i] !== expX(i)) begin
               testsFailed++;
               $display("[TB] FAIL random%0d_x%0d: got %h expected %h", iter, i, xAt(i), expX(i));
            end
         end
         for (int s = 0; s < b; s++) begin
            testsRun++;
            if (!tMem.exists(s) || tMem[s] !== expT(s)) begin
               testsFailed++;
               $display("[TB] FAIL random%0d_t%0d: got %h expected %h", iter, s, tAt(s), expT(s));
            end
         end
         testsRun++;
         if (timedOut != 0 || count !== W'(b) || doneCnt != 1 || spuriousWe != 0 || countErr != 0 || busyErr != 0) begin
            testsFailed++;
            $display("[TB] FAIL random%0d_summary: got timeout=%0d count=%0d pulses=%0d spurious=%0d countErr=%0d busyErr=%0d expected 0 %0d 1 0 0 0",
                     iter, timedOut, count, doneCnt, spuriousWe, countErr, busyErr, b);
         end
      end
   endtask

   task automatic test_zero_batch();
      stream.delete();
      driveRun(0, 0, -1, 0);
      testsRun++;
      if (xWrites != 0 || tWrites != 0 || readySeen != 0) begin
         testsFailed++;
         $display("[TB] FAIL zero_no_writes: got x=%0d t=%0d readyCycles=%0d expected 0 0 0", xWrites, tWrites, readySeen);
      end
      testsRun++;
      if (doneCycle != 1 || doneCnt != 1 || count !== 16'd0) begin
         testsFailed++;
         $display("[TB] FAIL zero_done: got doneCycle=%0d pulses=%0d count=%0d expected 1 1 0", doneCycle, doneCnt, count);
      end
   endtask

   task automatic test_reset_midrun();
      stream.delete();
      for (int i = 0; i < 3 * SW; i++) stream.push_back(W'($urandom));
      @(negedge clk);
      start = 1'b1;
      batch = 16'd3;
      in_valid = 1'b0;
      for (int m = 0; m < SW + SX + 1; m++) begin
         @(negedge clk);
         start = 1'b0;
         in_valid = 1'b1;
         in_data = stream[m];
      end
      @(negedge clk);
      in_valid = 1'b0;
      testsRun++;
      if (count !== 16'd1 || busy !== 1'b1 || in_ready !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL midrun_progress: got count=%0d busy=%b ready=%b expected 1 1 1", count, busy, in_ready);
      end
      #2 rst = 1'b0;
      #1;
      testsRun++;
      if ({in_ready, x_addr, x_din, x_we, t_addr, t_din, t_we, busy, done, count} !== '0) begin
         testsFailed++;
         $display("[TB] FAIL async_reset: got ready=%b xa=%0h xd=%0h xwe=%0h ta=%0h td=%0h twe=%0h busy=%b done=%b cnt=%0d, expected all zero",
                  in_ready, x_addr, x_din, x_we, t_addr, t_din, t_we, busy, done, count);
      end
      @(negedge clk);
      rst = 1'b1;
      stream.delete();
      for (int i = 0; i < SW; i++) stream.push_back(W'($urandom));
      driveRun(1, 0, -1, 0);
      testsRun++;
      if (!xMem.exists(0) || !xMem.exists(1) || xMem[0] !== expX(0) || xMem[1] !== expX(1)) begin
         testsFailed++;
         $display("[TB] FAIL restart_x: got %h %h expected %h %h", xAt(0), xAt(1), expX(0), expX(1));
      end
      testsRun++;
      if (!tMem.exists(0) || tMem[0] !== expT(0) || tWrites != 1 || count !== 16'd1) begin
         testsFailed++;
         $display("[TB] FAIL restart_t: got row0=%h writes=%0d count=%0d expected %h 1 1", tAt(0), tWrites, count, expT(0));
      end
   endtask

   task automatic test_start_ignored();
      stream.delete();
      for (int i = 0; i < 2 * SW; i++) stream.push_back(W'($urandom));
      driveRun(2, 0, 2, 5);
      testsRun++;
      if (tWrites != 2 || count !== 16'd2 || doneCycle != 2 * SW + 1) begin
         testsFailed++;
         $display("[TB] FAIL start_ignored: got t=%0d count=%0d doneCycle=%0d expected 2 2 %0d",
                  tWrites, count, doneCycle, 2 * SW + 1);
      end
      for (int s = 0; s < 2; s++) begin
         testsRun++;
         if (!tMem.exists(s) || tMem[s] !== expT(s)) begin
            testsFailed++;
            $display("[TB] FAIL start_ignored_t%0d: got %h expected %h", s, tAt(s), expT(s));
         end
      end
   endtask

   // Sequence of scenarios followed by the summary
   initial begin
      testsRun = 0;
      testsFailed = 0;
      test_reset();
      test_single();
      test_batch3();
      test_toggle();
      test_zero_batch();
      test_reset_midrun();
      test_start_ignored();
      test_random();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

   // Guard against a hung simulation
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
